mem_access_ctrl: RTL and testbench

- MEM-stage access controller of the 16-bit pipelined CPU; sits between the EX/MEM pipeline register and mem_wb.
- Turns a load/store request into a multi-cycle access on the shared external SRAM/UART data bus and stalls the pipeline until the access completes.
- Passes the write-back controls through to mem_wb and supplies the loaded data on memres_o.

---
 rtl/mem_access_ctrl.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : MEM-stage access controller for the 16-bit pipelined CPU.
//               A load or store from EX/MEM becomes a multi-cycle access on
//               the shared SRAM/UART data bus. The pipeline is stalled until
//               the access reaches DONE. The write-back controls are passed
//               through to mem_wb, and the loaded data is presented on
//               memres_o.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   CLK, RST               clock (rising edge); synchronous active-low reset
//   memread_i/memwrite_i   load / store request (both set => store)
//   memtoreg_i/_o          write-back select, passed through
//   regdst_i/_o            destination register, passed through
//   regwrite_i/_o          register write enable, masked while stalled
//   alures_i/_o            ALU result / memory address, passed through
//   wdata_i                store data
//   memres_o               registered load result
//   stall_o                freeze request to PC, IF/ID, ID/EX, EX/MEM
//   ram_addr_o             bus address (latched when an access starts)
//   ram_data_i/_o          bus read data / bus write data
//   ram_data_oe            bus driver enable
//   ram_ce_n/oe_n/we_n     SRAM strobes, active-low
//   uart_rdn/uart_wrn      UART strobes, active-low
//   uart_tbre/tsre/data_ready  UART status inputs
// ============================================================================
module mem_access_ctrl #(
  parameter int unsigned    WAIT_CYCLES    = 1,
  parameter logic [15:0]    UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0]    UART_STAT_ADDR = 16'hBF01
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic        memtoreg_i,
  input  logic [3:0]  regdst_i,
  input  logic        regwrite_i,
  input  logic [15:0] alures_i,
  input  logic [15:0] wdata_i,
  output logic        memtoreg_o,
  output logic [3:0]  regdst_o,
  output logic        regwrite_o,
  output logic [15:0] alures_o,
  output logic [15:0] memres_o,
  output logic        stall_o,
  output logic [15:0] ram_addr_o,
  input  logic [15:0] ram_data_i,
  output logic [15:0] ram_data_o,
  output logic        ram_data_oe,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_tbre,
  input  logic        uart_tsre,
  input  logic        uart_data_ready
);

  localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RD_WAIT   = 4'd1,
    S_RD_SAMPLE = 4'd2,
    S_WR_SETUP  = 4'd3,
    S_WR_PULSE  = 4'd4,
    S_WR_HOLD   = 4'd5,
    S_UR_WAIT   = 4'd6,
    S_UW_PULSE  = 4'd7,
    S_DONE      = 4'd8
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] memres_q, memres_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;

  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        rdn_q, rdn_d;
  logic        wrn_q, wrn_d;
  logic        doe_q, doe_d;

  logic        w_req;
  logic        w_is_write;
  logic        w_hit_data;
  logic        w_hit_stat;
  logic        w_cnt_last;

  assign w_req      = memread_i | memwrite_i;
  // A simultaneous read and write request is handled as a write.
  assign w_is_write = memwrite_i;
  assign w_hit_data = (alures_i == UART_DATA_ADDR);
  assign w_hit_stat = (alures_i == UART_STAT_ADDR);
  // The last cycle of a timed strobe. The "<=" also guards against a
  // zero count that could otherwise wrap around.
  assign w_cnt_last = (cnt_q <= 4'd1);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    memres_d = memres_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          addr_d  = alures_i;
          wdata_d = wdata_i;
          if (w_is_write) begin
            if (w_hit_data) begin
              state_d = S_UW_PULSE;
              cnt_d   = c_WAIT;
            end else if (w_hit_stat) begin
              // The status register is read-only; the store is dropped.
              state_d = S_DONE;
            end else begin
              state_d = S_WR_SETUP;
            end
          end else begin
            if (w_hit_data) begin
              state_d = S_UR_WAIT;
              cnt_d   = c_WAIT;
            end else if (w_hit_stat) begin
              memres_d = {14'b0, uart_data_ready, uart_tbre & uart_tsre};
              state_d  = S_DONE;
            end else begin
              state_d = S_RD_WAIT;
              cnt_d   = c_WAIT;
            end
          end
        end
      end

      S_RD_WAIT: begin
        if (w_cnt_last) begin
          cnt_d   = 4'd0;
          state_d = S_RD_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_RD_SAMPLE: begin
        memres_d = ram_data_i;
        state_d  = S_DONE;
      end

      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = c_WAIT;
      end

      S_WR_PULSE: begin
        if (w_cnt_last) begin
          cnt_d   = 4'd0;
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_WR_HOLD: begin
        state_d = S_DONE;
      end

      S_UR_WAIT: begin
        if (w_cnt_last) begin
          cnt_d    = 4'd0;
          memres_d = ram_data_i;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_UW_PULSE: begin
        if (w_cnt_last) begin
          cnt_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Bus strobe decode. The decode works on the state being entered, so the
  // registered strobes line up with the state that is entered at each edge.
  // --------------------------------------------------------------------------
  always_comb begin
    ce_n_d = 1'b1;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    rdn_d  = 1'b1;
    wrn_d  = 1'b1;
    doe_d  = 1'b0;

    case (state_d)
      S_RD_WAIT: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        ce_n_d = 1'b0;
        doe_d  = 1'b1;
      end
      S_WR_PULSE: begin
        ce_n_d = 1'b0;
        doe_d  = 1'b1;
        we_n_d = 1'b0;
      end
      S_UR_WAIT: begin
        rdn_d = 1'b0;
      end
      S_UW_PULSE: begin
        doe_d = 1'b1;
        wrn_d = 1'b0;
      end
      default: begin
        ce_n_d = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and bus registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      memres_q <= 16'd0;
      addr_q   <= 16'd0;
      wdata_q  <= 16'd0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      rdn_q    <= 1'b1;
      wrn_q    <= 1'b1;
      doe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      memres_q <= memres_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      rdn_q    <= rdn_d;
      wrn_q    <= wrn_d;
      doe_q    <= doe_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The stall is released in DONE so that EX/MEM and mem_wb advance once.
  assign stall_o     = w_req & (state_q != S_DONE);
  assign regwrite_o  = regwrite_i & ~stall_o;
  assign memtoreg_o  = memtoreg_i;
  assign regdst_o    = regdst_i;
  assign alures_o    = alures_i;
  assign memres_o    = memres_q;

  assign ram_addr_o  = addr_q;
  assign ram_data_o  = wdata_q;
  assign ram_data_oe = doe_q;
  assign ram_ce_n    = ce_n_q;
  assign ram_oe_n    = oe_n_q;
  assign ram_we_n    = we_n_q;
  assign uart_rdn    = rdn_q;
  assign uart_wrn    = wrn_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl. There are two
//               instances, with WAIT_CYCLES = 1 and 3. Directed and random
//               accesses are compared with a behavioural model of the
//               expected stall lengths, strobe activity and load results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  localparam int          W0    = 1;
  localparam int          W1    = 3;
  localparam logic [15:0] UDATA = 16'hBF00;
  localparam logic [15:0] USTAT = 16'hBF01;

  localparam int K_SRD  = 0;  // SRAM load
  localparam int K_SWR  = 1;  // SRAM store
  localparam int K_URD  = 2;  // UART data load
  localparam int K_UWR  = 3;  // UART data store
  localparam int K_STRD = 4;  // UART status load
  localparam int K_STWR = 5;  // UART status store (ignored)

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0]       memread, memwrite, memtoreg, regwrite;
  logic [1:0]       memtoreg_o, regwrite_o, stall, ram_doe;
  logic [1:0]       ce_n, oe_n, we_n, rdn, wrn, tbre, tsre, dready;
  logic [1:0][3:0]  regdst, regdst_o;
  logic [1:0][15:0] alures, wdata, alures_o, memres, ram_addr, ram_din, ram_dout;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] mdl_memres [2];

  always #5 clk = ~clk;

  mem_access_ctrl #(.WAIT_CYCLES(W0)) u_dut0 (
    .CLK(clk), .RST(rst_n),
    .memread_i(memread[0]), .memwrite_i(memwrite[0]), .memtoreg_i(memtoreg[0]),
    .regdst_i(regdst[0]), .regwrite_i(regwrite[0]), .alures_i(alures[0]), .wdata_i(wdata[0]),
    .memtoreg_o(memtoreg_o[0]), .regdst_o(regdst_o[0]), .regwrite_o(regwrite_o[0]),
    .alures_o(alures_o[0]), .memres_o(memres[0]), .stall_o(stall[0]),
    .ram_addr_o(ram_addr[0]), .ram_data_i(ram_din[0]), .ram_data_o(ram_dout[0]),
    .ram_data_oe(ram_doe[0]), .ram_ce_n(ce_n[0]), .ram_oe_n(oe_n[0]), .ram_we_n(we_n[0]),
    .uart_rdn(rdn[0]), .uart_wrn(wrn[0]),
    .uart_tbre(tbre[0]), .uart_tsre(tsre[0]), .uart_data_ready(dready[0])
  );

  mem_access_ctrl #(.WAIT_CYCLES(W1)) u_dut1 (
    .CLK(clk), .RST(rst_n),
    .memread_i(memread[1]), .memwrite_i(memwrite[1]), .memtoreg_i(memtoreg[1]),
    .regdst_i(regdst[1]), .regwrite_i(regwrite[1]), .alures_i(alures[1]), .wdata_i(wdata[1]),
    .memtoreg_o(memtoreg_o[1]), .regdst_o(regdst_o[1]), .regwrite_o(regwrite_o[1]),
    .alures_o(alures_o[1]), .memres_o(memres[1]), .stall_o(stall[1]),
    .ram_addr_o(ram_addr[1]), .ram_data_i(ram_din[1]), .ram_data_o(ram_dout[1]),
    .ram_data_oe(ram_doe[1]), .ram_ce_n(ce_n[1]), .ram_oe_n(oe_n[1]), .ram_we_n(we_n[1]),
    .uart_rdn(rdn[1]), .uart_wrn(wrn[1]),
    .uart_tbre(tbre[1]), .uart_tsre(tsre[1]), .uart_data_ready(dready[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  // Number of cycles with stall_o high for each kind of access.
  function automatic int exp_stall(input int k, input int w);
    case (k)
      K_SRD:        return w + 2;
      K_SWR:        return w + 3;
      K_URD, K_UWR: return w + 1;
      default:      return 1;
    endcase
  endfunction

  // Strobe pattern while idle/DONE: {ce_n, oe_n, we_n, rdn, wrn, data_oe}.
  function automatic logic [5:0] bus_of(input int d);
    return {ce_n[d], oe_n[d], we_n[d], rdn[d], wrn[d], ram_doe[d]};
  endfunction

  task automatic access(input int d, input int k, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [15:0] rdat,
                        input logic [2:0] st, input bit both, input bit rw);
    int w, cyc, ce_lo, oe_lo, we_lo, rd_lo, wr_lo, doe_hi, viol;
    int f_doe, f_we, l_doe, l_we;
    int e_ce, e_oe, e_we, e_rd, e_wr, e_doe;
    logic [3:0] rdst;
    logic       mtr;
    string      tg;
    w    = wait_of(d);
    rdst = 4'($urandom);
    mtr  = 1'($urandom);
    tg   = $sformatf("d%0d k%0d a%04h", d, k, addr);

    @(negedge clk);
    memread[d]  = (k == K_SRD || k == K_URD || k == K_STRD) ? 1'b1 : both;
    memwrite[d] = (k == K_SWR || k == K_UWR || k == K_STWR);
    alures[d]   = addr;
    wdata[d]    = wd;
    ram_din[d]  = rdat;
    dready[d]   = st[2];
    tbre[d]     = st[1];
    tsre[d]     = st[0];
    regwrite[d] = rw;
    regdst[d]   = rdst;
    memtoreg[d] = mtr;
    if (k == K_SRD || k == K_URD) mdl_memres[d] = rdat;
    else if (k == K_STRD)         mdl_memres[d] = {14'b0, st[2], st[1] & st[0]};
    #1;

    cyc = 0; ce_lo = 0; oe_lo = 0; we_lo = 0; rd_lo = 0; wr_lo = 0; doe_hi = 0; viol = 0;
    f_doe = -1; f_we = -1; l_doe = -1; l_we = -1;
    while (stall[d] === 1'b1 && cyc < 40) begin
      if (ce_n[d] === 1'b0) ce_lo++;
      if (oe_n[d] === 1'b0) oe_lo++;
      if (rdn[d]  === 1'b0) rd_lo++;
      if (wrn[d]  === 1'b0) wr_lo++;
      if (ram_doe[d] === 1'b1) begin
        if (f_doe < 0) f_doe = cyc;
        l_doe = cyc;
        doe_hi++;
      end
      if (we_n[d] === 1'b0) begin
        if (f_we < 0) f_we = cyc;
        l_we = cyc;
        we_lo++;
        if (ram_doe[d] !== 1'b1) viol++;
      end
      if (regwrite_o[d] !== 1'b0) viol++;
      cyc++;
      @(negedge clk); #1;
    end

    e_ce  = (k == K_SRD) ? w : (k == K_SWR) ? w + 2 : 0;
    e_oe  = (k == K_SRD) ? w : 0;
    e_we  = (k == K_SWR) ? w : 0;
    e_rd  = (k == K_URD) ? w : 0;
    e_wr  = (k == K_UWR) ? w : 0;
    e_doe = (k == K_SWR) ? w + 2 : (k == K_UWR) ? w : 0;

    // Now in the DONE cycle.
    chk({tg, " stall_cycles"}, 32'(cyc), 32'(exp_stall(k, w)));
    chk({tg, " memres"}, 32'(memres[d]), 32'(mdl_memres[d]));
    chk({tg, " bus_addr_data"}, {ram_addr[d], ram_dout[d]}, {addr, wd});
    chk({tg, " strobe_lows"}, {8'(ce_lo), 8'(oe_lo), 8'(we_lo), 8'(rd_lo)},
        {8'(e_ce), 8'(e_oe), 8'(e_we), 8'(e_rd)});
    chk({tg, " uart_wr_doe"}, {16'(wr_lo), 16'(doe_hi)}, {16'(e_wr), 16'(e_doe)});
    chk({tg, " done_bus_idle"}, 32'(bus_of(d)), 32'(6'b111110));
    chk({tg, " done_regwrite"}, {31'b0, regwrite_o[d]}, {31'b0, rw});
    chk({tg, " stall_violations"}, 32'(viol), 32'd0);
    chk({tg, " passthru"}, 32'({memtoreg_o[d], regdst_o[d], alures_o[d]}),
        32'({mtr, rdst, addr}));
    if (k == K_SWR)
      chk({tg, " wr_order"}, {8'(f_doe), 8'(f_we), 8'(l_we), 8'(l_doe)},
          {8'd1, 8'd2, 8'(w + 1), 8'(w + 2)});

    // Drop the request once DONE has passed. A following call can still
    // present its request in the very next IDLE cycle.
    @(posedge clk); #1;
    memread[d]  = 1'b0;
    memwrite[d] = 1'b0;
  endtask

  task automatic alu_op(input int d);
    @(negedge clk);
    memread[d]  = 1'b0;
    memwrite[d] = 1'b0;
    regwrite[d] = 1'b1;
    alures[d]   = 16'($urandom);
    ram_din[d]  = 16'($urandom);
    #1;
    chk($sformatf("d%0d alu stall", d), {31'b0, stall[d]}, 32'd0);
    chk($sformatf("d%0d alu regwrite", d), {31'b0, regwrite_o[d]}, 32'd1);
    @(negedge clk); #1;
    chk($sformatf("d%0d alu memres_hold", d), 32'(memres[d]), 32'(mdl_memres[d]));
    chk($sformatf("d%0d alu bus_idle", d), 32'(bus_of(d)), 32'(6'b111110));
  endtask

  task automatic random_access(input int d);
    int          k;
    logic [15:0] addr;
    k = int'($urandom_range(0, 5));
    case (k)
      K_SRD, K_SWR: addr = 16'($urandom_range(0, 32'h0000_BEFF));
      K_URD, K_UWR: addr = UDATA;
      default:      addr = USTAT;
    endcase
    access(d, k, addr, 16'($urandom), 16'($urandom), 3'($urandom),
           1'($urandom), 1'($urandom));
  endtask

  task automatic reset_mid_write();
    bit seen;
    int n;
    @(negedge clk);
    memwrite[1] = 1'b1;
    memread[1]  = 1'b0;
    alures[1]   = 16'h0200;
    wdata[1]    = 16'hBEEF;
    regwrite[1] = 1'b0;
    #1;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 10) begin
      @(negedge clk); #1;
      n++;
      if (we_n[1] === 1'b0) seen = 1'b1;
    end
    chk("rst reached_wr_pulse", {31'b0, seen}, 32'd1);
    // The reset and the pipeline flush arrive together.
    rst_n       = 1'b0;
    memwrite[1] = 1'b0;
    @(negedge clk); #1;
    chk("rst we_n_doe_ce", {29'b0, we_n[1], ram_doe[1], ce_n[1]}, 32'b101);
    chk("rst memres", 32'(memres[1]), 32'd0);
    chk("rst stall", {31'b0, stall[1]}, 32'd0);
    rst_n         = 1'b1;
    mdl_memres[0] = 16'd0;
    mdl_memres[1] = 16'd0;
  endtask

  initial begin
    rst_n    = 1'b0;
    memread  = '0; memwrite = '0; memtoreg = '0; regwrite = '0;
    regdst   = '0; alures   = '0; wdata    = '0; ram_din  = '0;
    tbre     = '0; tsre     = '0; dready   = '0;
    mdl_memres[0] = 16'd0;
    mdl_memres[1] = 16'd0;

    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d reset memres", d), 32'(memres[d]), 32'd0);
      chk($sformatf("d%0d reset stall", d), {31'b0, stall[d]}, 32'd0);
      chk($sformatf("d%0d reset bus", d), 32'(bus_of(d)), 32'(6'b111110));
    end
    rst_n = 1'b1;

    // Directed cases
    access(0, K_SRD,  16'h0040, 16'h0000, 16'hA5A5, 3'b000, 1'b0, 1'b1);
    access(0, K_SWR,  16'h0100, 16'h1234, 16'h0000, 3'b000, 1'b0, 1'b1);
    access(0, K_STRD, USTAT,    16'h0000, 16'h7777, 3'b111, 1'b0, 1'b1);
    access(1, K_UWR,  UDATA,    16'h0041, 16'h0000, 3'b000, 1'b0, 1'b0);
    access(1, K_URD,  UDATA,    16'h0000, 16'h5A5A, 3'b000, 1'b0, 1'b1);
    access(1, K_STWR, USTAT,    16'hFFFF, 16'h0000, 3'b000, 1'b1, 1'b0);
    access(1, K_SWR,  16'h0300, 16'hC0DE, 16'h0000, 3'b000, 1'b1, 1'b0);
    reset_mid_write();
    access(1, K_SRD,  16'h0044, 16'h0000, 16'h3C3C, 3'b000, 1'b0, 1'b1);
    // Two loads back-to-back, then an ALU op
    access(0, K_SRD,  16'h0010, 16'h0000, 16'h1111, 3'b000, 1'b0, 1'b1);
    access(0, K_URD,  UDATA,    16'h0000, 16'h2222, 3'b000, 1'b0, 1'b1);
    alu_op(0);

    // Random traffic on both instances
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) alu_op(i % 2);
      else random_access(i % 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
